// File: rtl/i2c_mem_slave_pkg.sv
// ---------------------------------------------------------------------------
// i2c_mem_slave_pkg
// Shared types and constants for the I2C memory slave.
//   slave_state_t : FSM state encoding (4 bits, visible on o_slave_state)
//   I2C_RW_READ   : value of the R/W bit that requests a read
//   I2C_ACK       : SDA level that signals acknowledge
//   I2C_BYTE_W    : width of every byte on the I2C wire
// ---------------------------------------------------------------------------
package i2c_mem_slave_pkg;

    localparam int   I2C_BYTE_W  = 8;
    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV_ADDR  = 4'd1,
        ST_RW        = 4'd2,
        ST_ACK_DEV   = 4'd3,
        ST_MEM_ADDR  = 4'd4,
        ST_ACK_ADDR  = 4'd5,
        ST_TX_DATA   = 4'd6,
        ST_RX_DATA   = 4'd7,
        ST_ACK_WR    = 4'd8,
        ST_MACK      = 4'd9,
        ST_WAIT_STOP = 4'd10
    } slave_state_t;

endpackage

// File: rtl/i2c_mem_slave_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_mem_slave_line_sync
// Synchronises the SCL/SDA line levels into the system clock domain and turns
// them into single-cycle event pulses.
//   i_clk, i_reset   : system clock, asynchronous active-high reset
//   i_scl, i_sda     : raw line levels
//   o_scl_rise/fall  : SCL edge pulses (suppressed when a START/STOP fires)
//   o_start, o_stop  : START / STOP condition pulses
//   o_sda            : synchronised SDA, aligned with the pulses above
// Pin change to pulse is SYNC_STAGES+1 clocks.
// ---------------------------------------------------------------------------
module i2c_mem_slave_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   r_scl_rise;
    logic                   r_scl_fall;
    logic                   r_start;
    logic                   r_stop;
    logic                   r_sda;

    logic w_scl;
    logic w_sda;
    logic w_scl_high;
    logic w_start;
    logic w_stop;

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    // SCL must be high on both sides of the SDA edge; an SDA edge that lands
    // in the same sample as an SCL rise is an ordinary data change.
    assign w_scl_high = w_scl & r_scl_prev;
    assign w_start    = w_scl_high &  r_sda_prev & ~w_sda;
    assign w_stop     = w_scl_high & ~r_sda_prev &  w_sda;

    // Idle bus is high on both lines, so the chain resets to 1 to avoid
    // spurious edges when reset releases.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_sda      <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
            r_start    <= w_start;
            r_stop     <= w_stop;
            r_scl_rise <=  w_scl & ~r_scl_prev & ~(w_start | w_stop);
            r_scl_fall <= ~w_scl &  r_scl_prev & ~(w_start | w_stop);
            r_sda      <= w_sda;
        end
    end

    assign o_scl_rise = r_scl_rise;
    assign o_scl_fall = r_scl_fall;
    assign o_start    = r_start;
    assign o_stop     = r_stop;
    assign o_sda      = r_sda;

endmodule

// File: rtl/i2c_mem_slave.sv
// ---------------------------------------------------------------------------
// i2c_mem_slave
// I2C responder that serves one-byte reads and writes of an attached memory.
// Frame: START, dev id[8], R/W, ACK, mem addr[8], ACK, data[8], ACK, STOP.
//   i_clk, i_reset         : system clock (>= 8x SCL), async active-high reset
//   i_scl_in, i_sda_in     : bus line levels
//   o_sda_oe               : 1 pulls SDA low (open drain)
//   i_dev_id               : device id this slave answers to
//   o_mem_ce/rden/wren     : single-cycle memory strobes
//   o_mem_addr, o_mem_wdata: memory address / write data (held between strobes)
//   i_mem_rdata            : memory read data, valid one clock after rden
//   o_slave_state, o_slave_data, o_slave_mem_address : debug visibility
// ---------------------------------------------------------------------------
module i2c_mem_slave
    import i2c_mem_slave_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_scl_in,
    input  logic              i_sda_in,
    output logic              o_sda_oe,
    input  logic [7:0]        i_dev_id,
    output logic              o_mem_ce,
    output logic              o_mem_rden,
    output logic              o_mem_wren,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [3:0]        o_slave_state,
    output logic [DATA_W-1:0] o_slave_data,
    output logic [ADDR_W-1:0] o_slave_mem_address
);

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_sda;

    slave_state_t            r_state;
    logic [2:0]              r_bit_cnt;
    logic [I2C_BYTE_W-1:0]   r_shift;
    logic                    r_rw;
    logic                    r_phase;
    logic                    r_rd_wait;
    logic                    r_sda_oe;
    logic                    r_mem_ce;
    logic                    r_mem_rden;
    logic                    r_mem_wren;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [DATA_W-1:0]       r_mem_wdata;
    logic [ADDR_W-1:0]       r_addr_lat;

    logic [I2C_BYTE_W-1:0]   w_shift_in;
    logic [2:0]              w_tx_idx;

    i2c_mem_slave_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_scl      (i_scl_in),
        .i_sda      (i_sda_in),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop),
        .o_sda      (w_sda)
    );

    assign w_shift_in = {r_shift[I2C_BYTE_W-2:0], w_sda};
    // Bit to present after the current one in TX_DATA (MSB already driven).
    assign w_tx_idx   = 3'd6 - r_bit_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rw        <= 1'b0;
            r_phase     <= 1'b0;
            r_rd_wait   <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_mem_ce    <= 1'b0;
            r_mem_rden  <= 1'b0;
            r_mem_wren  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_addr_lat  <= '0;
        end else begin
            // Strobes are one-clock pulses by default.
            r_mem_ce   <= 1'b0;
            r_mem_rden <= 1'b0;
            r_mem_wren <= 1'b0;

            // Read data appears one clock after rden; capture it then.
            r_rd_wait <= r_mem_rden;
            if (r_rd_wait) begin
                r_shift <= I2C_BYTE_W'(i_mem_rdata);
            end

            if (w_start) begin
                r_state   <= ST_DEV_ADDR;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
                r_phase   <= 1'b0;
            end else if (w_stop) begin
                r_state   <= ST_IDLE;
                r_sda_oe  <= 1'b0;
                r_phase   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end

                    ST_DEV_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_shift_in;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= ST_RW;
                                r_phase <= 1'b0;
                            end
                        end
                    end

                    // r_phase marks that R/W was sampled and the id matched;
                    // the ACK then starts on the following SCL fall.
                    ST_RW: begin
                        if (w_scl_rise) begin
                            r_rw <= w_sda;
                            if (r_shift == i_dev_id) begin
                                r_phase <= 1'b1;
                            end else begin
                                r_state <= ST_WAIT_STOP;
                            end
                        end else if (w_scl_fall && r_phase) begin
                            r_state  <= ST_ACK_DEV;
                            r_sda_oe <= ~I2C_ACK;
                            r_phase  <= 1'b0;
                        end
                    end

                    ST_ACK_DEV: begin
                        if (w_scl_fall) begin
                            r_sda_oe  <= 1'b0;
                            r_state   <= ST_MEM_ADDR;
                            r_bit_cnt <= '0;
                        end
                    end

                    ST_MEM_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_shift_in;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_addr_lat <= ADDR_W'(w_shift_in);
                                r_state    <= ST_ACK_ADDR;
                                r_phase    <= 1'b0;
                                if (r_rw == I2C_RW_READ) begin
                                    r_mem_ce   <= 1'b1;
                                    r_mem_rden <= 1'b1;
                                    r_mem_addr <= ADDR_W'(w_shift_in);
                                end
                            end
                        end
                    end

                    // Entered on an SCL rise: first fall starts the ACK,
                    // second fall ends it and hands over to the data byte.
                    ST_ACK_ADDR: begin
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda_oe <= ~I2C_ACK;
                                r_phase  <= 1'b1;
                            end else begin
                                r_phase   <= 1'b0;
                                r_bit_cnt <= '0;
                                if (r_rw == I2C_RW_READ) begin
                                    r_state  <= ST_TX_DATA;
                                    r_sda_oe <= ~r_shift[I2C_BYTE_W-1];
                                end else begin
                                    r_state  <= ST_RX_DATA;
                                    r_sda_oe <= 1'b0;
                                end
                            end
                        end
                    end

                    ST_TX_DATA: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd7) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_MACK;
                            end else begin
                                r_sda_oe  <= ~r_shift[w_tx_idx];
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end

                    // Master ACK/NACK is sampled but has no effect.
                    ST_MACK: begin
                        if (w_scl_rise) begin
                            r_state <= ST_WAIT_STOP;
                        end
                    end

                    ST_RX_DATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_shift_in;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_mem_ce    <= 1'b1;
                                r_mem_wren  <= 1'b1;
                                r_mem_addr  <= r_addr_lat;
                                r_mem_wdata <= DATA_W'(w_shift_in);
                                r_state     <= ST_ACK_WR;
                                r_phase     <= 1'b0;
                            end
                        end
                    end

                    ST_ACK_WR: begin
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda_oe <= ~I2C_ACK;
                                r_phase  <= 1'b1;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_phase  <= 1'b0;
                                r_state  <= ST_WAIT_STOP;
                            end
                        end
                    end

                    ST_WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                    end

                    default: begin
                        r_state  <= ST_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_sda_oe            = r_sda_oe;
    assign o_mem_ce            = r_mem_ce;
    assign o_mem_rden          = r_mem_rden;
    assign o_mem_wren          = r_mem_wren;
    assign o_mem_addr          = r_mem_addr;
    assign o_mem_wdata         = r_mem_wdata;
    assign o_slave_state       = r_state;
    assign o_slave_data        = DATA_W'(r_shift);
    assign o_slave_mem_address = r_addr_lat;

endmodule
